// File: rtl/arp_pkg.sv
// Shared ARP types and widths used by the lookup arbiter and its interface.
package arp_pkg;

  localparam int IP_W = 32;
  localparam int MAC_W = 48;
  localparam logic [MAC_W-1:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RETURN
  } arp_arb_state_t;

endpackage

// File: rtl/arp_req_arb_if.sv
// Client-side and ARP-side handshakes of the lookup arbiter, plus its status outputs.
interface arp_req_arb_if
  import arp_pkg::*;
#(
  parameter int PORTS = 4
);
  localparam int GW = $clog2(PORTS);

  logic [PORTS-1:0]      s_req_valid;
  logic [PORTS-1:0]      s_req_ready;
  logic [PORTS*IP_W-1:0] s_req_ip;
  logic [PORTS-1:0]      s_resp_valid;
  logic [PORTS-1:0]      s_resp_ready;
  logic                  s_resp_error;
  logic [MAC_W-1:0]      s_resp_mac;

  logic                  m_arp_request_valid;
  logic                  m_arp_request_ready;
  logic [IP_W-1:0]       m_arp_request_ip;
  logic                  m_arp_response_valid;
  logic                  m_arp_response_ready;
  logic                  m_arp_response_error;
  logic [MAC_W-1:0]      m_arp_response_mac;

  logic [GW-1:0]         grant;
  logic                  busy;
  logic                  timeout_pulse;

  // slave: the arbiter itself; master: requesters plus the ARP block
  modport slave (
    input  s_req_valid, s_req_ip, s_resp_ready,
    input  m_arp_request_ready, m_arp_response_valid, m_arp_response_error, m_arp_response_mac,
    output s_req_ready, s_resp_valid, s_resp_error, s_resp_mac,
    output m_arp_request_valid, m_arp_request_ip, m_arp_response_ready,
    output grant, busy, timeout_pulse
  );

  modport master (
    output s_req_valid, s_req_ip, s_resp_ready,
    output m_arp_request_ready, m_arp_response_valid, m_arp_response_error, m_arp_response_mac,
    input  s_req_ready, s_resp_valid, s_resp_error, s_resp_mac,
    input  m_arp_request_valid, m_arp_request_ip, m_arp_response_ready,
    input  grant, busy, timeout_pulse
  );

endinterface

// File: rtl/arp_rr_select.sv
// Round-robin priority encoder: lowest requester above last_grant, else lowest overall.
module arp_rr_select #(
  parameter int PORTS = 4
) (
  input  logic [PORTS-1:0]         req_i,
  input  logic [$clog2(PORTS)-1:0] last_grant_i,
  output logic [$clog2(PORTS)-1:0] sel_o,
  output logic                     any_o
);
  localparam int GW = $clog2(PORTS);

  logic [PORTS-1:0] masked;
  logic [GW-1:0]    sel_masked;
  logic [GW-1:0]    sel_plain;

  always_comb begin
    masked = '0;
    for (int i = 0; i < PORTS; i++) begin
      masked[i] = req_i[i] && (i > int'(last_grant_i));
    end
  end

  // Walk downward so the lowest set index is the one left standing.
  always_comb begin
    sel_masked = '0;
    sel_plain  = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (masked[i]) sel_masked = GW'(i);
      if (req_i[i])  sel_plain  = GW'(i);
    end
  end

  assign sel_o = (|masked) ? sel_masked : sel_plain;
  assign any_o = |req_i;

endmodule

// File: rtl/arp_req_arb.sv
// Shares one ARP lookup port among PORTS requesters, one lookup in flight,
// with an optional response watchdog that drains the late reply.
module arp_req_arb
  import arp_pkg::*;
#(
  parameter int          PORTS           = 4,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd0
) (
  input  logic         clk,
  input  logic         rst,
  arp_req_arb_if.slave bus
);
  localparam int GW = $clog2(PORTS);

  // state  | meaning
  // IDLE   | round-robin select among valid requesters
  // ISSUE  | lookup presented to ARP block, held off while a drain is pending
  // WAIT   | awaiting ARP response, watchdog counting down
  // RETURN | response presented to the granted requester

  arp_arb_state_t   state_q;
  logic [IP_W-1:0]  ip_q;
  logic [GW-1:0]    grant_q;
  logic [GW-1:0]    last_grant_q;
  logic [MAC_W-1:0] mac_q;
  logic             err_q;
  logic [31:0]      wd_cnt_q;
  logic             drop_q;
  logic             timeout_q;

  logic [GW-1:0]    sel;
  logic             any_req;
  logic [IP_W-1:0]  sel_ip;
  logic             resp_fire;
  logic             wd_en;

  assign wd_en     = (WATCHDOG_CYCLES != 32'd0);
  assign resp_fire = bus.m_arp_response_valid && bus.m_arp_response_ready;

  arp_rr_select #(.PORTS(PORTS)) u_rr_select (
    .req_i        (bus.s_req_valid),
    .last_grant_i (last_grant_q),
    .sel_o        (sel),
    .any_o        (any_req)
  );

  always_comb begin
    sel_ip = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (sel == GW'(i)) sel_ip = bus.s_req_ip[i*IP_W +: IP_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ip_q         <= '0;
      grant_q      <= '0;
      last_grant_q <= GW'(PORTS - 1);
      mac_q        <= '0;
      err_q        <= 1'b0;
      wd_cnt_q     <= '0;
      drop_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      // The reply that arrives after a timeout is swallowed in whatever state we are in.
      if (drop_q && resp_fire) drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            ip_q    <= sel_ip;
            grant_q <= sel;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!drop_q && bus.m_arp_request_ready) begin
            wd_cnt_q <= WATCHDOG_CYCLES - 32'd1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (resp_fire) begin
            mac_q   <= bus.m_arp_response_mac;
            err_q   <= bus.m_arp_response_error;
            state_q <= RETURN;
          end else if (wd_en) begin
            if (wd_cnt_q == 32'd0) begin
              mac_q     <= '0;
              err_q     <= 1'b1;
              timeout_q <= 1'b1;
              drop_q    <= 1'b1;
              state_q   <= RETURN;
            end else begin
              wd_cnt_q <= wd_cnt_q - 32'd1;
            end
          end
        end
        RETURN: begin
          if (bus.s_resp_ready[grant_q]) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_req_ready          = (state_q == IDLE && any_req) ? (PORTS'(1) << sel) : '0;
  assign bus.s_resp_valid         = (state_q == RETURN) ? (PORTS'(1) << grant_q) : '0;
  assign bus.s_resp_error         = err_q;
  assign bus.s_resp_mac           = mac_q;
  assign bus.m_arp_request_valid  = (state_q == ISSUE) && !drop_q;
  assign bus.m_arp_request_ip     = ip_q;
  assign bus.m_arp_response_ready = (state_q == WAIT) || drop_q;
  assign bus.grant                = grant_q;
  assign bus.busy                 = (state_q != IDLE) || drop_q;
  assign bus.timeout_pulse        = timeout_q;

endmodule

// File: tb/tb_arp_req_arb.sv
// Directed bench for arp_req_arb: reset, single lookup, fairness, backpressure,
// watchdog with drain, expiry tie and reset during WAIT.
module tb_arp_req_arb;

  localparam int PORTS = 4;

  localparam logic [47:0] MAC_A    = 48'h02_00_00_00_00_05;
  localparam logic [47:0] MAC_B    = 48'h02_11_22_33_44_55;
  localparam logic [47:0] MAC_F    = 48'h02_00_00_00_00_A0;
  localparam logic [47:0] MAC_LATE = 48'h02_DE_AD_BE_EF_00;
  localparam logic [47:0] MAC_P3   = 48'h02_00_00_00_03_03;
  localparam logic [47:0] MAC_T    = 48'h02_00_00_00_01_07;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_p;
  logic [3:0] oh;

  always #5 clk = ~clk;

  arp_req_arb_if #(.PORTS(PORTS)) bus ();

  arp_req_arb #(.PORTS(PORTS), .WATCHDOG_CYCLES(32'd10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ip(input int p, input logic [31:0] ip);
    bus.s_req_ip[p*32 +: 32] = ip;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".s_req_ready"},  64'(bus.s_req_ready),          64'h0);
    chk({tag, ".s_resp_valid"}, 64'(bus.s_resp_valid),         64'h0);
    chk({tag, ".m_req_valid"},  64'(bus.m_arp_request_valid),  64'h0);
    chk({tag, ".m_resp_ready"}, 64'(bus.m_arp_response_ready), 64'h0);
    chk({tag, ".timeout"},      64'(bus.timeout_pulse),        64'h0);
    chk({tag, ".busy"},         64'(bus.busy),                 64'h0);
    chk({tag, ".m_req_ip"},     64'(bus.m_arp_request_ip),     64'h0);
    chk({tag, ".s_resp_mac"},   64'(bus.s_resp_mac),           64'h0);
    chk({tag, ".s_resp_error"}, 64'(bus.s_resp_error),         64'h0);
    chk({tag, ".grant"},        64'(bus.grant),                64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst                      = 1'b1;
    bus.s_req_valid          = '0;
    bus.s_req_ip             = '0;
    bus.s_resp_ready         = '0;
    bus.m_arp_request_ready  = 1'b0;
    bus.m_arp_response_valid = 1'b0;
    bus.m_arp_response_error = 1'b0;
    bus.m_arp_response_mac   = '0;
    cyc();
    cyc();
    chk_reset("rst");
    rst = 1'b0;

    // single lookup: port 2, 10.0.0.5
    set_ip(2, 32'h0A00_0005);
    bus.s_req_valid = 4'b0100;
    #1;
    chk("t1.req_ready", 64'(bus.s_req_ready), 64'h4);
    cyc();
    bus.s_req_valid = '0;
    bus.m_arp_request_ready = 1'b1;
    #1;
    chk("t1.m_req_valid", 64'(bus.m_arp_request_valid), 64'h1);
    chk("t1.m_req_ip",    64'(bus.m_arp_request_ip),    64'h0A00_0005);
    chk("t1.grant",       64'(bus.grant),               64'h2);
    cyc();
    bus.m_arp_request_ready = 1'b0;
    #1;
    chk("t1.m_resp_ready", 64'(bus.m_arp_response_ready), 64'h1);
    chk("t1.m_req_done",   64'(bus.m_arp_request_valid),  64'h0);
    cyc();
    cyc();
    bus.m_arp_response_valid = 1'b1;
    bus.m_arp_response_mac   = MAC_A;
    bus.m_arp_response_error = 1'b0;
    #1;
    chk("t1.resp_not_yet", 64'(bus.s_resp_valid), 64'h0);
    cyc();
    bus.m_arp_response_valid = 1'b0;
    #1;
    chk("t1.s_resp_valid", 64'(bus.s_resp_valid), 64'h4);
    chk("t1.s_resp_mac",   64'(bus.s_resp_mac),   64'(MAC_A));
    chk("t1.s_resp_error", 64'(bus.s_resp_error), 64'h0);
    bus.s_resp_ready = 4'b0100;
    cyc();
    bus.s_resp_ready = '0;
    #1;
    chk("t1.busy_low",   64'(bus.busy),         64'h0);
    chk("t1.resp_clear", 64'(bus.s_resp_valid), 64'h0);

    // fairness: all ports valid from reset, zero-latency ARP block
    rst = 1'b1;
    for (int p = 0; p < PORTS; p++) set_ip(p, 32'hC0A8_0100 + 32'(p));
    bus.s_req_valid          = 4'hF;
    bus.s_resp_ready         = 4'hF;
    bus.m_arp_request_ready  = 1'b1;
    bus.m_arp_response_valid = 1'b1;
    bus.m_arp_response_mac   = MAC_F;
    cyc();
    rst = 1'b0;
    #1;
    for (int t = 0; t < 6; t++) begin
      exp_p = t % 4;
      oh    = 4'b0001 << exp_p;
      chk("t2.req_ready", 64'(bus.s_req_ready), 64'(oh));
      cyc();
      chk("t2.grant",    64'(bus.grant),            64'(exp_p));
      chk("t2.m_req_ip", 64'(bus.m_arp_request_ip), 64'(32'hC0A8_0100 + 32'(exp_p)));
      cyc();
      cyc();
      chk("t2.s_resp_valid", 64'(bus.s_resp_valid), 64'(oh));
      cyc();
    end
    bus.s_req_valid          = '0;
    bus.s_resp_ready         = '0;
    bus.m_arp_request_ready  = 1'b0;
    bus.m_arp_response_valid = 1'b0;

    // backpressure on both sides, port 1 (last grant was 1)
    set_ip(1, 32'h0A00_0101);
    bus.s_req_valid = 4'b0010;
    #1;
    chk("t3.req_ready", 64'(bus.s_req_ready), 64'h2);
    cyc();
    bus.s_req_valid = '0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3.m_req_valid_hold", 64'(bus.m_arp_request_valid),  64'h1);
      chk("t3.m_req_ip_hold",    64'(bus.m_arp_request_ip),     64'h0A00_0101);
      chk("t3.m_resp_ready_0",   64'(bus.m_arp_response_ready), 64'h0);
      cyc();
    end
    bus.m_arp_request_ready = 1'b1;
    #1;
    chk("t3.m_req_valid", 64'(bus.m_arp_request_valid), 64'h1);
    cyc();
    bus.m_arp_request_ready  = 1'b0;
    bus.m_arp_response_valid = 1'b1;
    bus.m_arp_response_mac   = MAC_B;
    bus.m_arp_response_error = 1'b1;
    cyc();
    bus.m_arp_response_valid = 1'b0;
    bus.m_arp_response_error = 1'b0;
    bus.s_req_valid          = 4'b0001;
    #1;
    for (int k = 0; k < 7; k++) begin
      chk("t3.s_resp_valid_hold", 64'(bus.s_resp_valid), 64'h2);
      chk("t3.s_resp_mac_hold",   64'(bus.s_resp_mac),   64'(MAC_B));
      chk("t3.s_resp_error_hold", 64'(bus.s_resp_error), 64'h1);
      chk("t3.no_req_ready",      64'(bus.s_req_ready),  64'h0);
      cyc();
    end
    bus.s_resp_ready = 4'b0010;
    bus.s_req_valid  = '0;
    cyc();
    bus.s_resp_ready = '0;
    #1;
    chk("t3.busy_low", 64'(bus.busy), 64'h0);

    // watchdog expiry on port 0, then port 3 held until the late reply drains
    set_ip(0, 32'h0A00_0009);
    bus.s_req_valid = 4'b0001;
    #1;
    chk("t4.req_ready", 64'(bus.s_req_ready), 64'h1);
    cyc();
    bus.s_req_valid = '0;
    bus.m_arp_request_ready = 1'b1;
    cyc();
    bus.m_arp_request_ready = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("t4.no_pulse_yet", 64'(bus.timeout_pulse), 64'h0);
      chk("t4.no_resp_yet",  64'(bus.s_resp_valid),  64'h0);
      cyc();
    end
    chk("t4.timeout_pulse", 64'(bus.timeout_pulse),        64'h1);
    chk("t4.s_resp_valid",  64'(bus.s_resp_valid),         64'h1);
    chk("t4.s_resp_error",  64'(bus.s_resp_error),         64'h1);
    chk("t4.s_resp_mac",    64'(bus.s_resp_mac),           64'h0);
    chk("t4.drain_ready",   64'(bus.m_arp_response_ready), 64'h1);
    bus.s_resp_ready = 4'b0001;
    set_ip(3, 32'h0A00_0303);
    bus.s_req_valid = 4'b1000;
    #1;
    chk("t4.req_ready_in_return", 64'(bus.s_req_ready), 64'h0);
    cyc();
    bus.s_resp_ready = '0;
    #1;
    chk("t4.pulse_single", 64'(bus.timeout_pulse), 64'h0);
    chk("t4.busy_drain",   64'(bus.busy),          64'h1);
    chk("t4.req_ready_p3", 64'(bus.s_req_ready),   64'h8);
    cyc();
    bus.s_req_valid = '0;
    bus.m_arp_request_ready = 1'b1;
    #1;
    for (int k = 14; k < 40; k++) begin
      chk("t4.issue_held",  64'(bus.m_arp_request_valid),  64'h0);
      chk("t4.drain_ready", 64'(bus.m_arp_response_ready), 64'h1);
      chk("t4.no_resp",     64'(bus.s_resp_valid),         64'h0);
      cyc();
    end
    bus.m_arp_response_valid = 1'b1;
    bus.m_arp_response_mac   = MAC_LATE;
    bus.m_arp_response_error = 1'b0;
    cyc();
    bus.m_arp_response_valid = 1'b0;
    bus.m_arp_response_mac   = '0;
    #1;
    chk("t4.issue_released", 64'(bus.m_arp_request_valid),  64'h1);
    chk("t4.m_req_ip_p3",    64'(bus.m_arp_request_ip),     64'h0A00_0303);
    chk("t4.drain_done",     64'(bus.m_arp_response_ready), 64'h0);
    chk("t4.late_not_sent",  64'(bus.s_resp_valid),         64'h0);
    cyc();
    bus.m_arp_request_ready  = 1'b0;
    bus.m_arp_response_valid = 1'b1;
    bus.m_arp_response_mac   = MAC_P3;
    cyc();
    bus.m_arp_response_valid = 1'b0;
    #1;
    chk("t4.p3_resp_valid", 64'(bus.s_resp_valid), 64'h8);
    chk("t4.p3_resp_mac",   64'(bus.s_resp_mac),   64'(MAC_P3));
    chk("t4.p3_resp_error", 64'(bus.s_resp_error), 64'h0);
    bus.s_resp_ready = 4'b1000;
    cyc();
    bus.s_resp_ready = '0;
    #1;
    chk("t4.busy_low", 64'(bus.busy), 64'h0);

    // response lands on the expiry cycle itself (port 1, last grant was 3)
    set_ip(1, 32'h0A00_0107);
    bus.s_req_valid = 4'b0010;
    #1;
    chk("t5.req_ready", 64'(bus.s_req_ready), 64'h2);
    cyc();
    bus.s_req_valid = '0;
    bus.m_arp_request_ready = 1'b1;
    cyc();
    bus.m_arp_request_ready = 1'b0;
    for (int k = 0; k < 9; k++) cyc();
    bus.m_arp_response_valid = 1'b1;
    bus.m_arp_response_mac   = MAC_T;
    bus.m_arp_response_error = 1'b0;
    cyc();
    bus.m_arp_response_valid = 1'b0;
    #1;
    chk("t5.no_timeout",   64'(bus.timeout_pulse),        64'h0);
    chk("t5.s_resp_valid", 64'(bus.s_resp_valid),         64'h2);
    chk("t5.s_resp_mac",   64'(bus.s_resp_mac),           64'(MAC_T));
    chk("t5.s_resp_error", 64'(bus.s_resp_error),         64'h0);
    chk("t5.no_drain",     64'(bus.m_arp_response_ready), 64'h0);
    bus.s_resp_ready = 4'b0010;
    cyc();
    bus.s_resp_ready = '0;
    #1;
    chk("t5.busy_low", 64'(bus.busy), 64'h0);

    // reset asserted while waiting on the ARP block
    set_ip(2, 32'h0A00_0209);
    bus.s_req_valid = 4'b0100;
    #1;
    chk("t6.req_ready", 64'(bus.s_req_ready), 64'h4);
    cyc();
    bus.s_req_valid = '0;
    bus.m_arp_request_ready = 1'b1;
    cyc();
    bus.m_arp_request_ready = 1'b0;
    #1;
    chk("t6.in_wait", 64'(bus.m_arp_response_ready), 64'h1);
    cyc();
    rst = 1'b1;
    cyc();
    chk_reset("t6");
    rst = 1'b0;
    set_ip(0, 32'h0A00_0010);
    bus.s_req_valid = 4'b0101;
    #1;
    chk("t6.port0_first", 64'(bus.s_req_ready), 64'h1);
    cyc();
    bus.s_req_valid = '0;
    #1;
    chk("t6.grant",       64'(bus.grant),               64'h0);
    chk("t6.m_req_ip",    64'(bus.m_arp_request_ip),    64'h0A00_0010);
    chk("t6.m_req_valid", 64'(bus.m_arp_request_valid), 64'h1);
    chk("t6.no_resp",     64'(bus.s_resp_valid),        64'h0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arp_req_arb.md
# arp_req_arb

Round-robin arbiter and sequencer that shares the single ARP lookup port (request IP in, response MAC/error out) among `PORTS` independent requesters, e.g. IP TX, ICMP and UDP paths. It sits between those clients and the ARP block. It keeps exactly one lookup outstanding and routes each response back to the requester that issued it. An optional watchdog returns an error to the requester if the ARP block stalls, then silently drains the late response.

## Interface
Parameters:
- `PORTS`, 4: number of requesters, 2..16.
- `WATCHDOG_CYCLES`, 0: response timeout in clk cycles, 32-bit. 0 disables the watchdog.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high. Must be the same reset as the ARP block.
- `s_req_valid`  in  PORTS: per-requester lookup request.
- `s_req_ready`  out  PORTS: one-hot accept.
- `s_req_ip`  in  PORTS*32: request IP; port i uses bits [32i+31:32i].
- `s_resp_valid`  out  PORTS: one-hot response valid.
- `s_resp_ready`  in  PORTS: per-requester response accept.
- `s_resp_error`  out  1: shared error flag; meaningful only with `s_resp_valid`.
- `s_resp_mac`  out  48: shared response MAC.
- `m_arp_request_valid` / `m_arp_request_ready`  out / in  1: handshake to the ARP block.
- `m_arp_request_ip`  out  32: request IP to the ARP block.
- `m_arp_response_valid` / `m_arp_response_ready`  in / out  1: handshake from the ARP block.
- `m_arp_response_error`  in  1: error flag from the ARP block.
- `m_arp_response_mac`  in  48: MAC from the ARP block.
- `grant`  out  clog2(PORTS): index of the current or last granted port.
- `busy`  out  1: high whenever the state is not IDLE or `drop_pending` is set.
- `timeout_pulse`  out  1: single-cycle pulse on watchdog expiry.

## Operation
The block is a four-state FSM: IDLE, ISSUE, WAIT, RETURN.

- **IDLE:** A round-robin select starts at `last_grant+1` mod PORTS. `s_req_ready[sel]` is driven combinationally for the selected valid port only. On handshake:
  - capture the IP and `sel`;
  - set `grant <= sel`;
  - go to ISSUE.
- **ISSUE:** Drive `m_arp_request_valid` with the registered IP, but only while `drop_pending` is 0. On `m_arp_request_ready`, load `wd_cnt <= WATCHDOG_CYCLES-1` and go to WAIT.
- **WAIT:** `m_arp_response_ready` is 1. On response handshake, latch the MAC and error and go to RETURN. If the watchdog is enabled, `wd_cnt` decrements each cycle.
  - If `wd_cnt==0` with no response that cycle: set error=1, MAC=0, pulse `timeout_pulse`, set `drop_pending`, go to RETURN.
  - A response arriving on the expiry cycle wins, and no timeout occurs.
- **RETURN:** `s_resp_valid[grant]` is 1. On `s_resp_ready[grant]`, set `last_grant <= grant` and go to IDLE.

Drain behaviour:
- While `drop_pending` is set, `m_arp_response_ready` is 1 in every state.
- The next response handshake is discarded and clears `drop_pending`.
- Outside WAIT and with `drop_pending`=0, `m_arp_response_ready` is 0.

General rules:
- Non-granted ports never see `s_req_ready` or `s_resp_valid`.
- Requesters must hold valid and IP stable until their handshake completes.

## Timing
- **Reset values:** all `s_req_ready`, `s_resp_valid`, `m_arp_request_valid`, `m_arp_response_ready`, `timeout_pulse` and `busy` are 0. `m_arp_request_ip`, `s_resp_mac` and `s_resp_error` are 0. `grant`=0 and `last_grant`=PORTS-1, so port 0 has first priority. `drop_pending` is 0 and the state is IDLE.
- **Request latency:** a request handshake in cycle T gives `m_arp_request_valid` in T+1.
- **Response latency:** an ARP response handshake in cycle R gives `s_resp_valid` in R+1.
- **Back-to-back:** after an `s_resp` handshake in cycle X, the next request can be accepted in X+1. Minimum turnaround is 4 cycles with a zero-latency ARP block.
- **Reset mid-operation:** returns to IDLE and clears `drop_pending`. No responses are emitted.

## Structure
- **Shared package `arp_pkg`:** `IP_W=32`, `MAC_W=48`, `MAC_BCAST=48'hFFFF_FFFF_FFFF`, and the `arp_arb_state_t` enum (IDLE, ISSUE, WAIT, RETURN).
- **Sub-module `arp_rr_select`:** combinational round-robin priority encoder. Inputs are the request vector and `last_grant`; outputs are `sel` and `any`. Implemented as a masked-then-unmasked priority encode.

## Test plan
- **Single lookup:** port 2 requests 10.0.0.5; the ARP block responds MAC 02:00:00:00:00:05 with error=0 after 3 cycles. Expect `s_resp_valid`=4'b0100, that MAC, error=0, and `busy` low one cycle after `s_resp` handshake.
- **Fairness:** all 4 ports hold valid continuously from reset. Expect grant order 0,1,2,3,0,1 and no port granted twice in a row.
- **Backpressure:** `m_arp_request_ready` low for 5 cycles and `s_resp_ready[1]` low for 7 cycles. Expect request IP and response MAC held stable, with no extra handshakes.
- **Watchdog:** `WATCHDOG_CYCLES`=10, no ARP response. Expect `timeout_pulse` 10 cycles after request acceptance and error=1, MAC=0 to the requester. A port-3 request is then held in ISSUE until the late response arrives at cycle 40 and is drained. The late MAC is never presented to port 3.
- **Expiry tie:** response arrives on the exact expiry cycle. Expect normal response delivery, no `timeout_pulse`, and `drop_pending`=0.
- **Reset mid-WAIT:** assert `rst` during WAIT. Expect all outputs at reset values the next cycle, and a fresh port-0 request accepted after release.
